// File: rtl/bus_responder_pkg.sv
// Shared definitions for bus_responder: bus field widths, register addresses,
// STATUS bit layout and the address decoder.
package bus_responder_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CYCLES  = 8'hF0;
  localparam logic [ADDR_W-1:0] ADDR_CONSOLE = 8'hF1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'hF2;

  localparam int STAT_CNT_LSB   = 0;
  localparam int STAT_CNT_W     = 5;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_OVF_BIT   = 7;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_CYCLES,
    REG_CONSOLE,
    REG_STATUS
  } region_e;

  function automatic region_e decode_addr(input logic [ADDR_W-1:0] addr,
                                          input int unsigned        ram_words);
    if (32'(addr) < ram_words) return REG_RAM;
    case (addr)
      ADDR_CYCLES:  return REG_CYCLES;
      ADDR_CONSOLE: return REG_CONSOLE;
      ADDR_STATUS:  return REG_STATUS;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Controller request/response bus plus the console byte stream of bus_responder.
interface bus_responder_if;
  import bus_responder_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        con_data;
  logic              con_valid;
  logic              con_ready;

  modport master (
    output addr, rd, wr, wdata, con_ready,
    input  rdata, con_data, con_valid
  );

  modport slave (
    input  addr, rd, wr, wdata, con_ready,
    output rdata, con_data, con_valid
  );
endinterface

// File: rtl/bus_resp_fifo.sv
// Power-of-two synchronous FIFO; a push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module bus_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  // Pointers are exactly log2(DEPTH) bits, so increments wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; validity is tracked by the
  // pointers/count, and leaving memories out of reset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/bus_responder.sv
// Bus responder: data RAM, CYCLES counter, console FIFO and STATUS register.
// Define BUS_RESPONDER_CYCLES_EN to build the free-running CYCLES counter.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_WORDS  = 240
) (
  input logic             clk,
  input logic             rst_n,
  bus_responder_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  region_e           region;
  logic [DATA_W-1:0] ram_q [RAM_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] cycles_val;
  logic              ovf_q, ovf_d;
  logic              ram_wr, con_push, con_pop, fifo_drop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign region   = decode_addr(bus.addr, RAM_WORDS);
  assign ram_wr   = bus.wr && (region == REG_RAM);
  assign con_push = bus.wr && (region == REG_CONSOLE);
  assign con_pop  = bus.con_valid && bus.con_ready;

  bus_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (con_push),
    .push_data (bus.wdata[7:0]),
    .pop       (con_pop),
    .head_data (bus.con_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign bus.con_valid = !fifo_empty;

`ifdef BUS_RESPONDER_CYCLES_EN
  logic [DATA_W-1:0] cycles_q, cycles_d;

  assign cycles_d = cycles_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles_val = cycles_q;
`else
  assign cycles_val = '0;
`endif

  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[bus.addr] <= bus.wdata;
  end

  // STATUS reflects registered state only, so a same-cycle push/pop is not visible.
  always_comb begin
    status_word                              = '0;
    status_word[STAT_OVF_BIT]                = ovf_q;
    status_word[STAT_FULL_BIT]               = fifo_full;
    status_word[STAT_EMPTY_BIT]              = fifo_empty;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]  = STAT_CNT_W'(fifo_count);
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    rd_mux = '0;
    case (region)
      REG_RAM:    rd_mux = ram_q[bus.addr];
      REG_CYCLES: rd_mux = cycles_val;
      REG_STATUS: rd_mux = status_word;
      default:    rd_mux = '0;
    endcase
  end

  // A write wins over a simultaneous read, leaving rdata untouched.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.rd && !bus.wr) rdata_d = rd_mux;
  end

  // Overflow set is evaluated after the clear so a dropped push wins.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr && (region == REG_STATUS)) ovf_d = 1'b0;
    if (fifo_drop)                         ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed testbench for bus_responder (default parameters FIFO_DEPTH=4, RAM_WORDS=240).
module tb_bus_responder;

  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  bus_responder_if bus ();

  bus_responder #(
    .FIFO_DEPTH (4),
    .RAM_WORDS  (240)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr    = 1'b1;
    step();
    bus.wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    bus.addr = a;
    bus.rd   = 1'b1;
    step();
    bus.rd   = 1'b0;
  endtask

  logic [7:0]  drain_exp [4];
  logic [31:0] cycles_exp;

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.addr      = '0;
    bus.rd        = 1'b0;
    bus.wr        = 1'b0;
    bus.wdata     = '0;
    bus.con_ready = 1'b0;
    drain_exp     = '{8'h42, 8'h43, 8'h44, 8'h50};
`ifdef BUS_RESPONDER_CYCLES_EN
    cycles_exp = 32'd10;
`else
    cycles_exp = 32'd0;
`endif

    // Reset state
    step();
    step();
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_con_valid", {31'b0, bus.con_valid}, 32'h0);
    check("reset_con_data", {24'b0, bus.con_data}, 32'h0);
    rst_n = 1'b1;

    // CYCLES: ten edges after release, then rd sampled while CYCLES == 10
    for (int i = 0; i < 10; i++) step();
    bus_read(8'hF0);
    check("cycles_at_10", bus.rdata, cycles_exp);

    // RAM write then read, rdata held while idle
    bus_write(8'h05, 32'h1234_5678);
    bus_read(8'h05);
    check("ram_wr_rd_05", bus.rdata, 32'h1234_5678);
    step();
    check("rdata_hold", bus.rdata, 32'h1234_5678);

    // Top RAM word and unmapped addresses
    bus_write(8'hEF, 32'hCAFE_F00D);
    bus_read(8'hEF);
    check("ram_last_word", bus.rdata, 32'hCAFE_F00D);
    bus_write(8'hF5, 32'hFFFF_FFFF);
    bus_read(8'hF5);
    check("unmapped_read", bus.rdata, 32'h0);

    // Simultaneous rd and wr: write only, rdata holds
    bus_write(8'h10, 32'hAAAA_0001);
    bus_read(8'h05);
    check("pre_rdwr_rdata", bus.rdata, 32'h1234_5678);
    bus.addr  = 8'h10;
    bus.wdata = 32'hBBBB_0002;
    bus.rd    = 1'b1;
    bus.wr    = 1'b1;
    step();
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    check("rdwr_rdata_hold", bus.rdata, 32'h1234_5678);
    bus_read(8'h10);
    check("rdwr_ram_updated", bus.rdata, 32'hBBBB_0002);

    // Empty STATUS
    bus_read(8'hF2);
    check("status_empty", bus.rdata, 32'h20);

    // Five pushes into a depth-4 FIFO with sink stalled
    bus_write(8'hF1, 32'h0000_0041);
    check("first_push_valid", {31'b0, bus.con_valid}, 32'h1);
    check("first_push_data", {24'b0, bus.con_data}, 32'h41);
    for (int b = 8'h42; b <= 8'h45; b++) bus_write(8'hF1, 32'(b));
    bus_read(8'hF2);
    check("status_overflow_full", bus.rdata, 32'hC4);

    // Clear overflow, then push into full FIFO while popping
    bus_write(8'hF2, 32'h0);
    bus_read(8'hF2);
    check("status_ovf_cleared", bus.rdata, 32'h44);
    check("head_before_pushpop", {24'b0, bus.con_data}, 32'h41);
    bus.con_ready = 1'b1;
    bus_write(8'hF1, 32'h0000_0050);
    bus.con_ready = 1'b0;
    bus_read(8'hF2);
    check("status_after_pushpop", bus.rdata, 32'h44);

    // Drain
    bus.con_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'b0, bus.con_valid}, 32'h1);
      check($sformatf("drain_data_%0d", i), {24'b0, bus.con_data}, {24'b0, drain_exp[i]});
      step();
    end
    check("drained_valid", {31'b0, bus.con_valid}, 32'h0);
    bus.con_ready = 1'b0;

    // STATUS read in the same cycle as a pop returns the pre-pop count
    bus_write(8'hF1, 32'h0000_0060);
    bus.con_ready = 1'b1;
    bus_read(8'hF2);
    bus.con_ready = 1'b0;
    check("status_same_cycle_pop", bus.rdata, 32'h01);
    check("pop_done_valid", {31'b0, bus.con_valid}, 32'h0);

    // Asynchronous reset with two bytes queued and a read in flight
    bus_write(8'hF1, 32'h0000_0071);
    bus_write(8'hF1, 32'h0000_0072);
    check("queued_valid", {31'b0, bus.con_valid}, 32'h1);
    bus.addr = 8'h05;
    bus.rd   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_con_valid", {31'b0, bus.con_valid}, 32'h0);
    check("async_rst_rdata", bus.rdata, 32'h0);
    check("async_rst_con_data", {24'b0, bus.con_data}, 32'h0);
    bus.rd = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    bus_read(8'hF2);
    check("status_after_reset", bus.rdata, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
